// File: rtl/bitty_pkg.sv
// rtl/bitty_pkg.sv - shared encodings and fetch state for the bitty fetch unit
package bitty_pkg;

    localparam logic [1:0] FMT_REG = 2'b00;
    localparam logic [1:0] FMT_IMM = 2'b01;
    localparam logic [1:0] FMT_BR  = 2'b10;

    localparam logic [1:0] BR_EQ   = 2'b00;
    localparam logic [1:0] BR_GT   = 2'b01;
    localparam logic [1:0] BR_LT   = 2'b10;
    localparam logic [1:0] BR_NONE = 2'b11;

    localparam logic [1:0] CMP_EQ  = 2'b00;
    localparam logic [1:0] CMP_GT  = 2'b01;
    localparam logic [1:0] CMP_LT  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_NEXT
    } fetch_state_t;

endpackage

// File: rtl/bitty_branch_resolve.sv
// rtl/bitty_branch_resolve.sv - next-pc selection for branch-format instructions
module bitty_branch_resolve
    import bitty_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [15:0]       i_inst,
    input  logic [1:0]        i_alu_cmp,
    input  logic [ADDR_W-1:0] i_pc,
    output logic [ADDR_W-1:0] o_next_pc
);

    logic [1:0]         w_cond;
    logic               w_taken;
    logic [ADDR_W+11:0] w_target_ext;
    logic               w_unused_hi;

    assign w_cond  = i_inst[3:2];
    // BR_NONE never matches, even if the compare result happens to equal 2'b11
    assign w_taken = (i_inst[1:0] == FMT_BR) && (w_cond != BR_NONE) && (w_cond == i_alu_cmp);

    assign w_target_ext = {{ADDR_W{1'b0}}, i_inst[15:4]};
    assign w_unused_hi  = ^w_target_ext[ADDR_W+11:ADDR_W];

    assign o_next_pc = w_taken ? w_target_ext[ADDR_W-1:0] : i_pc + ADDR_W'(1);

endmodule

// File: rtl/bitty_fetch_unit.sv
// rtl/bitty_fetch_unit.sv - program counter, instruction fetch and issue sequencing
module bitty_fetch_unit
    import bitty_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_valid,
    output logic [15:0]       d_inst,
    output logic              run,
    input  logic              done,
    input  logic [1:0]        alu_cmp,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic [15:0]       instr_count
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_d_inst;
    logic [15:0]       r_instr_count;
    logic              r_stop;
    logic              w_stop_nxt;
    logic [ADDR_W-1:0] w_next_pc;

    bitty_branch_resolve #(.ADDR_W(ADDR_W)) u_branch (
        .i_inst    (r_d_inst),
        .i_alu_cmp (alu_cmp),
        .i_pc      (r_pc),
        .o_next_pc (w_next_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_FETCH;
            ST_FETCH: if (mem_valid) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (done) w_state_nxt = ST_NEXT;
            ST_NEXT:  w_state_nxt = (r_stop || stop) ? ST_IDLE : ST_FETCH;
            default:  w_state_nxt = ST_IDLE;
        endcase
        // Stop request is remembered until the unit drops back to IDLE
        w_stop_nxt = (w_state_nxt == ST_IDLE) ? 1'b0 : (r_stop | stop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_d_inst      <= '0;
            r_instr_count <= '0;
            r_stop        <= 1'b0;
        end else begin
            r_stop <= w_stop_nxt;
            if (r_state == ST_FETCH && mem_valid) r_d_inst <= mem_rdata;
            if (r_state == ST_NEXT) begin
                r_pc          <= w_next_pc;
                r_instr_count <= r_instr_count + 16'd1;
            end
        end
    end

    assign mem_rd      = (r_state == ST_FETCH);
    assign mem_addr    = r_pc;
    assign run         = (r_state == ST_ISSUE);
    assign busy        = (r_state != ST_IDLE);
    assign pc          = r_pc;
    assign d_inst      = r_d_inst;
    assign instr_count = r_instr_count;

endmodule
